wb_stim_responder: RTL and testbench

Parametrised Wishbone slave that serves the core's bus on the testbench side of the GUVM interface. It replaces cycle-counted load-data injection with a decoded responder:
- Instruction fetches are served from an instruction queue.
- Data-window reads are served from a data queue.
- Writes are captured into a FIFO that the result monitor drains.
Ack timing is programmable through a wait-state count.

---
 rtl/wb_stim_if.sv | 28 ++
 rtl/wb_stim_responder.sv | 262 ++++++++++++++++++++++++++
 tb/tb_wb_stim_responder.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_stim_if.sv
// wb_stim_if: Wishbone classic bus bundle between the core (master) and the
// stimulus responder (slave).
//   adr    master->slave  address
//   sel    master->slave  byte selects
//   we     master->slave  write enable
//   dat_w  master->slave  write data
//   cyc    master->slave  bus cycle
//   stb    master->slave  strobe
//   dat_r  slave->master  read data
//   ack    slave->master  acknowledge
//   err    slave->master  error
interface wb_stim_if #(
    parameter int DW = 32,
    parameter int AW = 32
);
    logic [AW-1:0]   adr;
    logic [DW/8-1:0] sel;
    logic            we;
    logic [DW-1:0]   dat_w;
    logic            cyc;
    logic            stb;
    logic [DW-1:0]   dat_r;
    logic            ack;
    logic            err;

    modport master (output adr, sel, we, dat_w, cyc, stb, input dat_r, ack, err);
    modport slave  (input adr, sel, we, dat_w, cyc, stb, output dat_r, ack, err);
endinterface

// File: rtl/wb_stim_responder.sv
// wb_stim_responder: Wishbone slave that answers the core's bus from the
// testbench side. Instruction fetches pop the instruction queue, reads that
// hit the data window pop the data queue, and writes are captured into a FIFO
// drained by the result monitor. Ack is delayed by a programmable wait-state
// count sampled when the request is accepted.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   wait_states         extra cycles before ack (sampled at request start)
//   bus (slave)         Wishbone adr/sel/we/dat_w/cyc/stb in, dat_r/ack/err out
//   inst_push/word/full instruction queue load port
//   data_push/word/full load-data queue port
//   wr_valid/ready      capture FIFO head handshake
//   wr_adr/dat/sel      captured write fields at the FIFO head
//   fetch_cnt           number of acknowledged instruction fetches
//
// Optional feature: define WB_STIM_ERR_EN to terminate a fetch or data read
// that finds its queue empty with a one-cycle err instead of stalling.
// Without it err is tied low.

// Small synchronous FIFO; callers pass already-qualified write/read enables.
module wb_stim_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [PW:0]   count_reg;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (wr_en) wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (rd_en) rd_ptr_reg <= rd_ptr_reg + PW'(1);
            case ({wr_en, rd_en})
                2'b10:   count_reg <= count_reg + (PW+1)'(1);
                2'b01:   count_reg <= count_reg - (PW+1)'(1);
                default: ;
            endcase
        end
    end

    assign head  = mem[rd_ptr_reg];
    assign full  = (count_reg == (PW+1)'(DEPTH));
    assign empty = (count_reg == '0);
endmodule

module wb_stim_responder #(
    parameter int DW       = 32,
    parameter int AW       = 32,
    parameter int IQ_DEPTH = 8,
    parameter int DQ_DEPTH = 4,
    parameter int WQ_DEPTH = 4,
    parameter int WS_W     = 4,
    parameter logic [AW-1:0] DATA_BASE = AW'(32'h0000_8000),
    parameter logic [AW-1:0] DATA_MASK = AW'(32'hFFFF_8000)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [WS_W-1:0] wait_states,
    wb_stim_if.slave        bus,
    input  logic            inst_push,
    input  logic [DW-1:0]   inst_word,
    output logic            inst_full,
    input  logic            data_push,
    input  logic [DW-1:0]   data_word,
    output logic            data_full,
    output logic            wr_valid,
    input  logic            wr_ready,
    output logic [AW-1:0]   wr_adr,
    output logic [DW-1:0]   wr_dat,
    output logic [DW/8-1:0] wr_sel,
    output logic [31:0]     fetch_cnt
);
    localparam int SW = DW / 8;
    localparam int CW = AW + DW + SW;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;
    typedef enum logic [1:0] {REQ_FETCH, REQ_DREAD, REQ_WRITE} req_t;

    state_t          state_reg, state_next;
    req_t            kind_reg, kind_next;
    logic [WS_W-1:0] cnt_reg, cnt_next;
    logic [AW-1:0]   adr_reg, adr_next;
    logic [DW-1:0]   wdat_reg, wdat_next;
    logic [SW-1:0]   sel_reg, sel_next;
    logic [DW-1:0]   rdat_reg, rdat_next;
    logic            resp_err_reg, resp_err_next;
    logic [31:0]     fetch_cnt_reg, fetch_cnt_next;

    logic            inst_wr, inst_pop, inst_empty;
    logic [DW-1:0]   inst_head;
    logic            data_wr, data_pop, data_empty;
    logic [DW-1:0]   data_head;
    logic            cap_push, cap_pop, cap_full, cap_empty, cap_ready;
    logic [CW-1:0]   cap_head;

    // Full is judged before any same-cycle pop, so a push into a full queue
    // is dropped even if a word leaves on the same edge.
    assign inst_wr = inst_push & ~inst_full;
    assign data_wr = data_push & ~data_full;

    // A full capture FIFO can still accept a write on the edge its head drains.
    assign cap_pop   = wr_valid & wr_ready;
    assign cap_ready = ~cap_full | cap_pop;
    assign wr_valid  = ~cap_empty;
    assign {wr_adr, wr_dat, wr_sel} = cap_head;

    wb_stim_fifo #(.W(DW), .DEPTH(IQ_DEPTH)) u_inst_q (
        .clk(clk), .rst(rst), .wr_en(inst_wr), .wr_data(inst_word),
        .rd_en(inst_pop), .head(inst_head), .full(inst_full), .empty(inst_empty)
    );

    wb_stim_fifo #(.W(DW), .DEPTH(DQ_DEPTH)) u_data_q (
        .clk(clk), .rst(rst), .wr_en(data_wr), .wr_data(data_word),
        .rd_en(data_pop), .head(data_head), .full(data_full), .empty(data_empty)
    );

    wb_stim_fifo #(.W(CW), .DEPTH(WQ_DEPTH)) u_cap_q (
        .clk(clk), .rst(rst), .wr_en(cap_push), .wr_data({adr_reg, wdat_reg, sel_reg}),
        .rd_en(cap_pop), .head(cap_head), .full(cap_full), .empty(cap_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            kind_reg      <= REQ_FETCH;
            cnt_reg       <= '0;
            adr_reg       <= '0;
            wdat_reg      <= '0;
            sel_reg       <= '0;
            rdat_reg      <= '0;
            resp_err_reg  <= 1'b0;
            fetch_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            kind_reg      <= kind_next;
            cnt_reg       <= cnt_next;
            adr_reg       <= adr_next;
            wdat_reg      <= wdat_next;
            sel_reg       <= sel_next;
            rdat_reg      <= rdat_next;
            resp_err_reg  <= resp_err_next;
            fetch_cnt_reg <= fetch_cnt_next;
        end
    end

    // All queue side effects happen on the WAIT->RESP edge so that the
    // registered read data and fetch count line up with the ack cycle.
    always_comb begin
        state_next     = state_reg;
        kind_next      = kind_reg;
        cnt_next       = cnt_reg;
        adr_next       = adr_reg;
        wdat_next      = wdat_reg;
        sel_next       = sel_reg;
        rdat_next      = rdat_reg;
        resp_err_next  = resp_err_reg;
        fetch_cnt_next = fetch_cnt_reg;
        inst_pop       = 1'b0;
        data_pop       = 1'b0;
        cap_push       = 1'b0;

        unique case (state_reg)
            ST_IDLE: begin
                if (bus.cyc && bus.stb) begin
                    adr_next  = bus.adr;
                    wdat_next = bus.dat_w;
                    sel_next  = bus.sel;
                    // Byte selects play no part in classification.
                    if (bus.we)
                        kind_next = REQ_WRITE;
                    else if ((bus.adr & DATA_MASK) == DATA_BASE)
                        kind_next = REQ_DREAD;
                    else
                        kind_next = REQ_FETCH;
                    cnt_next   = wait_states;
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!bus.cyc) begin
                    state_next = ST_IDLE;
                end else if (cnt_reg != '0) begin
                    cnt_next = cnt_reg - WS_W'(1);
                end else begin
                    case (kind_reg)
                        REQ_FETCH: begin
                            if (!inst_empty) begin
                                inst_pop       = 1'b1;
                                rdat_next      = inst_head;
                                fetch_cnt_next = fetch_cnt_reg + 32'd1;
                                resp_err_next  = 1'b0;
                                state_next     = ST_RESP;
                            end
`ifdef WB_STIM_ERR_EN
                            else begin
                                resp_err_next = 1'b1;
                                state_next    = ST_RESP;
                            end
`endif
                        end
                        REQ_DREAD: begin
                            if (!data_empty) begin
                                data_pop      = 1'b1;
                                rdat_next     = data_head;
                                resp_err_next = 1'b0;
                                state_next    = ST_RESP;
                            end
`ifdef WB_STIM_ERR_EN
                            else begin
                                resp_err_next = 1'b1;
                                state_next    = ST_RESP;
                            end
`endif
                        end
                        REQ_WRITE: begin
                            if (cap_ready) begin
                                cap_push      = 1'b1;
                                resp_err_next = 1'b0;
                                state_next    = ST_RESP;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ST_RESP: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    assign bus.dat_r = rdat_reg;
    assign bus.ack   = (state_reg == ST_RESP) & ~resp_err_reg;
`ifdef WB_STIM_ERR_EN
    assign bus.err   = (state_reg == ST_RESP) & resp_err_reg;
`else
    assign bus.err   = 1'b0;
`endif
    assign fetch_cnt = fetch_cnt_reg;
endmodule

// File: tb/tb_wb_stim_responder.sv
// tb_wb_stim_responder: directed and randomized checks of wb_stim_responder
// against a queue-based reference model. Honours WB_STIM_ERR_EN when defined.
module tb_wb_stim_responder;
    localparam int DW   = 32;
    localparam int AW   = 32;
    localparam int IQ   = 8;
    localparam int DQ   = 4;
    localparam int WQ   = 4;
    localparam int WS_W = 4;

    typedef struct {
        logic [AW-1:0]   adr;
        logic [DW-1:0]   dat;
        logic [DW/8-1:0] sel;
    } cap_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [WS_W-1:0] wait_states = '0;
    logic            inst_push = 1'b0;
    logic [DW-1:0]   inst_word = '0;
    logic            inst_full;
    logic            data_push = 1'b0;
    logic [DW-1:0]   data_word = '0;
    logic            data_full;
    logic            wr_valid;
    logic            wr_ready = 1'b0;
    logic [AW-1:0]   wr_adr;
    logic [DW-1:0]   wr_dat;
    logic [DW/8-1:0] wr_sel;
    logic [31:0]     fetch_cnt;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state
    logic [DW-1:0] iq[$];
    logic [DW-1:0] dq[$];
    cap_t          cq[$];
    logic [31:0]   fcnt = '0;
    logic [DW-1:0] last_dat = '0;

    // Main-sequence scratch
    int            lat;
    logic [DW-1:0] rd;
    logic [1:0]    resp;
    logic          saw;
    cap_t          ce;

    wb_stim_if #(.DW(DW), .AW(AW)) bus ();

    wb_stim_responder #(
        .DW(DW), .AW(AW), .IQ_DEPTH(IQ), .DQ_DEPTH(DQ), .WQ_DEPTH(WQ), .WS_W(WS_W)
    ) dut (
        .clk(clk), .rst(rst), .wait_states(wait_states), .bus(bus),
        .inst_push(inst_push), .inst_word(inst_word), .inst_full(inst_full),
        .data_push(data_push), .data_word(data_word), .data_full(data_full),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_adr(wr_adr),
        .wr_dat(wr_dat), .wr_sel(wr_sel), .fetch_cnt(fetch_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Drive one request; lat = edges from strobe until ack/err (-1 on timeout).
    task automatic bus_req(input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                           input logic [DW/8-1:0] sel, input int ws, input int budget,
                           output int l, output logic [DW-1:0] rdat, output logic [1:0] r);
        wait_states = WS_W'(ws);
        bus.adr = adr; bus.we = we; bus.dat_w = dat; bus.sel = sel;
        bus.cyc = 1'b1; bus.stb = 1'b1;
        l = -1; rdat = '0; r = 2'b00;
        for (int i = 1; i <= budget; i++) begin
            tick();
            if (bus.ack === 1'b1 || bus.err === 1'b1) begin
                l = i; rdat = bus.dat_r; r = {bus.ack, bus.err};
                break;
            end
        end
        bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0;
        tick();
        $display("txn %s adr=%h ws=%0d lat=%0d ack_err=%b rdat=%h",
                 we ? "write" : "read ", adr, ws, l, r, rdat);
    endtask

    task automatic push_inst(input logic [DW-1:0] w);
        inst_push = 1'b1; inst_word = w;
        tick();
        inst_push = 1'b0;
        if (iq.size() < IQ) iq.push_back(w);
        check("inst_full", 64'(inst_full), 64'(iq.size() == IQ));
        $display("txn push_inst word=%h depth=%0d", w, iq.size());
    endtask

    task automatic push_data(input logic [DW-1:0] w);
        data_push = 1'b1; data_word = w;
        tick();
        data_push = 1'b0;
        if (dq.size() < DQ) dq.push_back(w);
        check("data_full", 64'(data_full), 64'(dq.size() == DQ));
        $display("txn push_data word=%h depth=%0d", w, dq.size());
    endtask

    task automatic do_read(input logic [AW-1:0] adr, input int ws, input logic is_fetch);
        int l; logic [DW-1:0] rdat; logic [1:0] r; logic [DW-1:0] exp;
        if (is_fetch) begin exp = iq.pop_front(); fcnt++; end
        else exp = dq.pop_front();
        last_dat = exp;
        bus_req(1'b0, adr, DW'($urandom), '1, ws, ws + 8, l, rdat, r);
        check("read_latency", 64'(l), 64'(ws + 2));
        check("read_ack_err", 64'(r), 64'(2'b10));
        check("read_data", 64'(rdat), 64'(exp));
        check("fetch_cnt", 64'(fetch_cnt), 64'(fcnt));
        check("ack_one_cycle", 64'(bus.ack), 64'(0));
    endtask

    task automatic do_write(input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                            input logic [DW/8-1:0] sel, input int ws);
        int l; logic [DW-1:0] rdat; logic [1:0] r; cap_t e;
        e.adr = adr; e.dat = dat; e.sel = sel;
        cq.push_back(e);
        bus_req(1'b1, adr, dat, sel, ws, ws + 8, l, rdat, r);
        check("write_latency", 64'(l), 64'(ws + 2));
        check("write_ack_err", 64'(r), 64'(2'b10));
        check("write_dat_r_held", 64'(rdat), 64'(last_dat));
        check("wr_valid_after_write", 64'(wr_valid), 64'(1));
    endtask

    task automatic do_drain();
        cap_t e;
        e = cq.pop_front();
        check("wr_valid", 64'(wr_valid), 64'(1));
        check("wr_adr", 64'(wr_adr), 64'(e.adr));
        check("wr_dat", 64'(wr_dat), 64'(e.dat));
        check("wr_sel", 64'(wr_sel), 64'(e.sel));
        wr_ready = 1'b1;
        tick();
        wr_ready = 1'b0;
        check("wr_valid_after_drain", 64'(wr_valid), 64'(cq.size() != 0));
        $display("txn drain adr=%h dat=%h sel=%b left=%0d", e.adr, e.dat, e.sel, cq.size());
    endtask

    initial begin
        bus.adr = '0; bus.sel = '0; bus.we = 1'b0; bus.dat_w = '0;
        bus.cyc = 1'b0; bus.stb = 1'b0;

        // Reset state
        tick(); tick();
        check("rst_ack", 64'(bus.ack), 64'(0));
        check("rst_err", 64'(bus.err), 64'(0));
        check("rst_dat", 64'(bus.dat_r), 64'(0));
        check("rst_wr_valid", 64'(wr_valid), 64'(0));
        check("rst_fetch_cnt", 64'(fetch_cnt), 64'(0));
        check("rst_inst_full", 64'(inst_full), 64'(0));
        check("rst_data_full", 64'(data_full), 64'(0));
        rst = 1'b0;
        tick();

        // First fetch, zero wait states
        push_inst(32'hE3A01005);
        do_read(32'h0000_0000, 0, 1'b1);

        // Data read with wait states; instruction queue must be untouched
        push_inst(32'h1111_1111);
        push_data(32'hDEADBEEF);
        do_read(32'h0000_8004, 3, 1'b0);
        do_read(32'h0001_8000, 0, 1'b1);   // outside window: high bits set

        // Captured write held while the monitor is not ready
        do_write(32'h0000_8010, 32'h1234_5678, 4'b0011, 0);
        tick(); tick(); tick();
        do_drain();

        // Fill capture FIFO, then a fifth write must wait for a drain
        for (int i = 0; i < WQ; i++)
            do_write(AW'($urandom), DW'($urandom), 4'($urandom), $urandom_range(0, 2));
        wait_states = '0;
        bus.adr = 32'h0000_8020; bus.dat_w = 32'h5555_AAAA; bus.sel = 4'b1100;
        bus.we = 1'b1; bus.cyc = 1'b1; bus.stb = 1'b1;
        saw = 1'b0;
        for (int i = 0; i < 5; i++) begin tick(); if (bus.ack === 1'b1) saw = 1'b1; end
        check("full_write_stall", 64'(saw), 64'(0));
        check("full_head_adr", 64'(wr_adr), 64'(cq[0].adr));
        wr_ready = 1'b1;
        tick();
        wr_ready = 1'b0;
        void'(cq.pop_front());
        saw = bus.ack;
        if (saw !== 1'b1) begin tick(); saw = bus.ack; end
        check("full_write_ack", 64'(saw), 64'(1));
        ce.adr = 32'h0000_8020; ce.dat = 32'h5555_AAAA; ce.sel = 4'b1100;
        cq.push_back(ce);
        bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0;
        tick();
        $display("txn write adr=00008020 after drain ack=%b", saw);
        for (int i = 0; i < WQ; i++) do_drain();

        // Fetch with an empty instruction queue
`ifdef WB_STIM_ERR_EN
        bus_req(1'b0, 32'h0000_0100, '0, '1, 1, 10, lat, rd, resp);
        check("empty_fetch_latency", 64'(lat), 64'(3));
        check("empty_fetch_ack_err", 64'(resp), 64'(2'b01));
        check("empty_fetch_dat_held", 64'(rd), 64'(last_dat));
        check("empty_fetch_cnt", 64'(fetch_cnt), 64'(fcnt));
`else
        wait_states = WS_W'(1);
        bus.adr = 32'h0000_0100; bus.we = 1'b0; bus.cyc = 1'b1; bus.stb = 1'b1;
        saw = 1'b0;
        for (int i = 0; i < 6; i++) begin tick(); if (bus.ack === 1'b1) saw = 1'b1; end
        check("empty_fetch_stall", 64'(saw), 64'(0));
        inst_push = 1'b1; inst_word = 32'h0BAD_F00D;
        tick();
        inst_push = 1'b0;
        check("no_bypass", 64'(bus.ack), 64'(0));
        tick();
        fcnt++; last_dat = 32'h0BAD_F00D;
        check("ack_after_push", 64'(bus.ack), 64'(1));
        check("ack_after_push_dat", 64'(bus.dat_r), 64'(32'h0BAD_F00D));
        check("ack_after_push_cnt", 64'(fetch_cnt), 64'(fcnt));
        bus.cyc = 1'b0; bus.stb = 1'b0;
        tick();
        $display("txn read  adr=00000100 stalled fetch served after push");
`endif

        // Cycle dropped during WAIT: nothing popped
        push_data(32'hA5A5_5A5A);
        bus_req(1'b0, 32'h0000_8000, '0, '1, 7, 3, lat, rd, resp);
        saw = 1'b0;
        for (int i = 0; i < 10; i++) begin tick(); if (bus.ack === 1'b1) saw = 1'b1; end
        check("cyc_drop_no_ack", 64'(saw), 64'(0));
        do_read(32'h0000_8000, 0, 1'b0);

        // Queue-full boundaries: overflow pushes are dropped
        for (int i = 0; i < IQ + 1; i++) push_inst(DW'($urandom));
        for (int i = 0; i < IQ; i++) do_read(AW'($urandom) & 32'hFFFF_7FFC, $urandom_range(0, 1), 1'b1);
        for (int i = 0; i < DQ + 1; i++) push_data(DW'($urandom));
        for (int i = 0; i < DQ; i++) do_read(32'h0000_8000 | (AW'($urandom) & 32'h7FFC), 0, 1'b0);

        // Reset in the middle of a data read's wait period
        do_write(32'h0000_8040, 32'h0F0F_0F0F, 4'b1111, 0);
        push_inst(32'h7777_7777);
        push_data(32'hCAFE_F00D);
        wait_states = WS_W'(5);
        bus.adr = 32'h0000_8008; bus.we = 1'b0; bus.cyc = 1'b1; bus.stb = 1'b1;
        tick(); tick();
        #2 rst = 1'b1;
        #1;
        check("midrst_ack", 64'(bus.ack), 64'(0));
        check("midrst_err", 64'(bus.err), 64'(0));
        check("midrst_dat", 64'(bus.dat_r), 64'(0));
        check("midrst_wr_valid", 64'(wr_valid), 64'(0));
        check("midrst_fetch_cnt", 64'(fetch_cnt), 64'(0));
        saw = 1'b0;
        for (int i = 0; i < 3; i++) begin tick(); if (bus.ack === 1'b1 || bus.err === 1'b1) saw = 1'b1; end
        check("midrst_no_resp", 64'(saw), 64'(0));
        bus.cyc = 1'b0; bus.stb = 1'b0;
        rst = 1'b0;
        iq.delete(); dq.delete(); cq.delete(); fcnt = '0; last_dat = '0;
        tick();
        $display("txn reset during data read wait");
        push_inst(32'h3333_4444);
        do_read(32'h0000_0040, 0, 1'b1);
        push_data(32'h9999_8888);
        do_read(32'h0000_8000, 1, 1'b0);

        // Randomized traffic against the model
        for (int n = 0; n < 150; n++) begin
            int op;
            op = $urandom_range(0, 5);
            case (op)
                0: push_inst(DW'($urandom));
                1: push_data(DW'($urandom));
                2: if (iq.size() > 0) do_read(AW'($urandom) & 32'hFFFF_7FFC, $urandom_range(0, 3), 1'b1);
                   else push_inst(DW'($urandom));
                3: if (dq.size() > 0) do_read(32'h0000_8000 | (AW'($urandom) & 32'h7FFC), $urandom_range(0, 3), 1'b0);
                   else push_data(DW'($urandom));
                4: if (cq.size() < WQ) do_write(AW'($urandom), DW'($urandom), 4'($urandom), $urandom_range(0, 3));
                   else do_drain();
                default: if (cq.size() > 0) do_drain();
                         else do_write(AW'($urandom), DW'($urandom), 4'($urandom), $urandom_range(0, 3));
            endcase
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
